// File: rtl/cheat_patch_engine.sv
// Multi-slot cheat substitution engine between the console cartridge bus and the ROM.
// Debounced address -> ROM fetch -> per-slot match/compare -> substituted byte to the console.
module cheat_patch_engine #(
    parameter int NUM_SLOTS  = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int DEBOUNCE   = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 13'h1FFC,
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [ADDR_WIDTH-1:0] CONSOLE_ADDR,
    input  logic [DATA_WIDTH-1:0] CART_DATA,
    output logic [ADDR_WIDTH-1:0] CART_ADDR,
    output logic [DATA_WIDTH-1:0] CONSOLE_DATA,
    output logic                  CONSOLE_DATA_OE,
    input  logic                  LOAD_VALID,
    output logic                  LOAD_READY,
    input  logic [SLOT_W-1:0]     LOAD_SLOT,
    input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
    input  logic [DATA_WIDTH-1:0] LOAD_DATA,
    input  logic [DATA_WIDTH-1:0] LOAD_COMPARE,
    input  logic                  LOAD_USE_COMPARE,
    input  logic                  LOAD_ENABLE,
    input  logic                  ARM,
    output logic                  ACTIVE,
    output logic [NUM_SLOTS-1:0]  HIT
);
    typedef enum logic [1:0] {ST_LOAD, ST_PENDING, ST_ACTIVE} state_t;
    state_t state_q, state_d;

    localparam logic [2:0] DB_MAX = 3'(DEBOUNCE);

    logic [ADDR_WIDTH-1:0] raw_q, addr_q;
    logic [2:0]            cnt_q, cnt_d;
    logic                  addr_same, accept, acc_q;

    logic [ADDR_WIDTH-1:0] slot_addr_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] slot_data_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] slot_cmp_q  [NUM_SLOTS];
    logic                  slot_use_q  [NUM_SLOTS];
    logic                  slot_en_q   [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] win_data    [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]  addr_hit, full_hit, win;
    logic [NUM_SLOTS-1:0]  amatch1_q, amatch2_q, hit_q;
    logic [ADDR_WIDTH-1:0] cart_addr_q;
    logic [DATA_WIDTH-1:0] data_q, console_data_q, console_data_d, sub_data;
    logic                  live1_q, live2_q, msb2_q, oe_q, load_fire;

    // Debounce: an address is accepted once it has been seen on DEBOUNCE+1 consecutive edges.
    always_comb begin
        addr_same = (CONSOLE_ADDR == raw_q);
        accept    = addr_same && (cnt_q == DB_MAX - 3'd1);
        cnt_d     = 3'd0;
        if (addr_same) begin
            cnt_d = (cnt_q == DB_MAX) ? cnt_q : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            raw_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            acc_q  <= 1'b0;
        end else begin
            raw_q <= CONSOLE_ADDR;
            cnt_q <= cnt_d;
            acc_q <= accept;
            if (accept) begin
                addr_q <= raw_q;
            end
        end
    end

    assign load_fire = LOAD_VALID && LOAD_READY;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic wr;
            assign wr = load_fire && (LOAD_SLOT == SLOT_W'(gi));

            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    slot_addr_q[gi] <= '0;
                    slot_data_q[gi] <= '0;
                    slot_cmp_q[gi]  <= '0;
                    slot_use_q[gi]  <= 1'b0;
                    slot_en_q[gi]   <= 1'b0;
                end else if (wr) begin
                    slot_addr_q[gi] <= LOAD_ADDR;
                    slot_data_q[gi] <= LOAD_DATA;
                    slot_cmp_q[gi]  <= LOAD_COMPARE;
                    slot_use_q[gi]  <= LOAD_USE_COMPARE;
                    slot_en_q[gi]   <= LOAD_ENABLE;
                end
            end

            // Address 0 marks an unused slot, so it never matches.
            assign addr_hit[gi] = slot_en_q[gi] && (slot_addr_q[gi] != '0) &&
                                  (slot_addr_q[gi] == addr_q);
            assign full_hit[gi] = amatch2_q[gi] && (!slot_use_q[gi] || (data_q == slot_cmp_q[gi]));
            assign win_data[gi] = win[gi] ? slot_data_q[gi] : '0;
        end
    endgenerate

    // Isolate the lowest set bit: lowest-index slot wins.
    assign win = full_hit & (~full_hit + NUM_SLOTS'(1));

    always_comb begin
        sub_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            sub_data = sub_data | win_data[i];
        end
        console_data_d = (live2_q && (|win)) ? sub_data : data_q;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Arming completes only on a fresh acceptance of the reset vector.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (ARM) state_d = ST_PENDING;
            ST_PENDING: if (acc_q && (addr_q == RESET_VECTOR)) state_d = ST_ACTIVE;
            default:    state_d = state_q;
        endcase
    end

    always_comb begin
        LOAD_READY = (state_q == ST_LOAD);
        ACTIVE     = (state_q == ST_ACTIVE);
    end

    // live1/live2 carry "accepted while ACTIVE" alongside each address, so the
    // reset-vector fetch that arms the engine is itself never substituted.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cart_addr_q    <= '0;
            amatch1_q      <= '0;
            live1_q        <= 1'b0;
            data_q         <= '0;
            amatch2_q      <= '0;
            msb2_q         <= 1'b0;
            live2_q        <= 1'b0;
            console_data_q <= '0;
            oe_q           <= 1'b0;
            hit_q          <= '0;
        end else begin
            cart_addr_q    <= addr_q;
            amatch1_q      <= addr_hit;
            live1_q        <= (state_q == ST_ACTIVE);
            data_q         <= CART_DATA;
            amatch2_q      <= amatch1_q;
            msb2_q         <= cart_addr_q[ADDR_WIDTH-1];
            live2_q        <= live1_q;
            console_data_q <= console_data_d;
            oe_q           <= (state_q != ST_LOAD) && msb2_q;
            hit_q          <= hit_q | (live2_q ? win : '0);
        end
    end

    assign CART_ADDR       = cart_addr_q;
    assign CONSOLE_DATA    = console_data_q;
    assign CONSOLE_DATA_OE = oe_q;
    assign HIT             = hit_q;

endmodule

// File: tb/tb_cheat_patch_engine.sv
// Directed bench for cheat_patch_engine: reset, debounce, arming, compare, priority, reset mid-run.
module tb_cheat_patch_engine;
    localparam int NS = 6;

    logic        clk;
    logic        rst_n;
    logic [12:0] console_addr;
    logic [7:0]  cart_data;
    logic [12:0] cart_addr;
    logic [7:0]  console_data;
    logic        console_oe;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  load_slot;
    logic [12:0] load_addr;
    logic [7:0]  load_data;
    logic [7:0]  load_cmp;
    logic        load_use;
    logic        load_en;
    logic        arm;
    logic        active;
    logic [NS-1:0] hit;

    logic [7:0] rom [0:8191];
    int errors = 0;
    int checks = 0;

    cheat_patch_engine #(
        .NUM_SLOTS(NS),
        .ADDR_WIDTH(13),
        .DATA_WIDTH(8),
        .DEBOUNCE(2),
        .RESET_VECTOR(13'h1FFC)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N(rst_n),
        .CONSOLE_ADDR(console_addr),
        .CART_DATA(cart_data),
        .CART_ADDR(cart_addr),
        .CONSOLE_DATA(console_data),
        .CONSOLE_DATA_OE(console_oe),
        .LOAD_VALID(load_valid),
        .LOAD_READY(load_ready),
        .LOAD_SLOT(load_slot),
        .LOAD_ADDR(load_addr),
        .LOAD_DATA(load_data),
        .LOAD_COMPARE(load_cmp),
        .LOAD_USE_COMPARE(load_use),
        .LOAD_ENABLE(load_en),
        .ARM(arm),
        .ACTIVE(active),
        .HIT(hit)
    );

    assign cart_data = rom[cart_addr];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic load_slot_t(input logic [2:0] slot, input logic [12:0] a, input logic [7:0] d,
                               input logic [7:0] c, input logic use_c, input logic en,
                               input logic with_arm);
        @(negedge clk);
        load_valid = 1'b1;
        load_slot  = slot;
        load_addr  = a;
        load_data  = d;
        load_cmp   = c;
        load_use   = use_c;
        load_en    = en;
        arm        = with_arm;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        arm        = 1'b0;
    endtask

    // Present an address and wait the full DEBOUNCE+4 edges before sampling.
    task automatic serve(input logic [12:0] a);
        @(negedge clk);
        console_addr = a;
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            rom[i] = 8'(i) ^ 8'h3C;
        end
        rom[13'h1234] = 8'hA5;
        rom[13'h1200] = 8'h05;

        rst_n = 1'b0;
        console_addr = '0;
        load_valid = 1'b0;
        load_slot = '0;
        load_addr = '0;
        load_data = '0;
        load_cmp = '0;
        load_use = 1'b0;
        load_en = 1'b0;
        arm = 1'b0;

        #5;
        check("rst_cart_addr", 32'(cart_addr), 32'h0);
        check("rst_console_data", 32'(console_data), 32'h0);
        check("rst_oe", 32'(console_oe), 32'h0);
        check("rst_load_ready", 32'(load_ready), 32'h1);
        check("rst_active", 32'(active), 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Passthrough in LOAD
        @(negedge clk);
        console_addr = 13'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pass_cart_addr_early", 32'(cart_addr), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("pass_cart_addr", 32'(cart_addr), 32'h1234);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pass_data", 32'(console_data), 32'hA5);
        check("pass_oe", 32'(console_oe), 32'h0);
        check("pass_active", 32'(active), 32'h0);
        repeat (4) @(negedge clk);
        check("pass_data_hold", 32'(console_data), 32'hA5);

        // Debounce: toggling never accepted, two-edge hold not enough
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            console_addr = (k % 2 == 1) ? 13'h1001 : 13'h1000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        console_addr = 13'h1000;
        @(posedge clk);
        @(negedge clk);
        check("deb_toggle_reject", 32'(cart_addr), 32'h1234);
        console_addr = 13'h1001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("deb_two_edges", 32'(cart_addr), 32'h1234);
        @(posedge clk);
        @(negedge clk);
        check("deb_accept", 32'(cart_addr), 32'h1001);

        // Load slots; the last write rides along with ARM
        load_slot_t(3'd0, 13'h1100, 8'hEA, 8'h00, 1'b0, 1'b1, 1'b0);
        load_slot_t(3'd3, 13'h1200, 8'h00, 8'h05, 1'b1, 1'b1, 1'b0);
        load_slot_t(3'd1, 13'h1300, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0);
        load_slot_t(3'd2, 13'h1300, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0);
        load_slot_t(3'd5, 13'h0000, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0);
        load_slot_t(3'd6, 13'h1400, 8'h99, 8'h00, 1'b0, 1'b1, 1'b0);
        check("load_ready_before_arm", 32'(load_ready), 32'h1);
        load_slot_t(3'd4, 13'h1500, 8'h44, 8'h00, 1'b0, 1'b1, 1'b1);
        check("load_ready_pending", 32'(load_ready), 32'h0);

        // Arming
        serve(13'h1100);
        check("pend_data", 32'(console_data), 32'h3C);
        check("pend_oe", 32'(console_oe), 32'h1);
        check("pend_active", 32'(active), 32'h0);
        serve(13'h1FFC);
        check("arm_active", 32'(active), 32'h1);
        check("arm_vector_data", 32'(console_data), 32'hC0);
        check("arm_hit_none", 32'(hit), 32'h0);
        serve(13'h1100);
        check("sub_data", 32'(console_data), 32'hEA);
        check("sub_hit", 32'(hit), 32'h01);

        // Compare mode
        serve(13'h1200);
        check("cmp_match_data", 32'(console_data), 32'h00);
        check("cmp_match_hit", 32'(hit), 32'h09);
        serve(13'h1100);
        rom[13'h1200] = 8'h06;
        serve(13'h1200);
        check("cmp_miss_data", 32'(console_data), 32'h06);

        // Priority and boundaries
        serve(13'h1300);
        check("prio_data", 32'(console_data), 32'h11);
        check("prio_hit", 32'(hit), 32'h0B);
        serve(13'h0000);
        check("addr0_data", 32'(console_data), 32'h3C);
        check("addr0_oe", 32'(console_oe), 32'h0);
        serve(13'h1400);
        check("oor_slot_data", 32'(console_data), 32'h3C);
        serve(13'h1500);
        check("arm_write_data", 32'(console_data), 32'h44);
        load_slot_t(3'd0, 13'h1100, 8'hBB, 8'h00, 1'b0, 1'b1, 1'b0);
        load_slot_t(3'd5, 13'h1600, 8'h66, 8'h00, 1'b0, 1'b1, 1'b0);
        serve(13'h1100);
        check("active_write_slot0", 32'(console_data), 32'hEA);
        serve(13'h1600);
        check("active_write_slot5", 32'(console_data), 32'h3C);
        check("final_hit", 32'(hit), 32'h1B);
        check("active_load_ready", 32'(load_ready), 32'h0);

        // Reset mid-run with a hit in flight
        @(negedge clk);
        console_addr = 13'h1300;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", 32'(console_oe), 32'h0);
        check("mid_rst_active", 32'(active), 32'h0);
        check("mid_rst_hit", 32'(hit), 32'h0);
        check("mid_rst_load_ready", 32'(load_ready), 32'h1);
        check("mid_rst_data", 32'(console_data), 32'h0);
        check("mid_rst_cart_addr", 32'(cart_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        arm = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arm = 1'b0;
        serve(13'h1FFC);
        check("post_rst_active", 32'(active), 32'h1);
        serve(13'h1100);
        check("post_rst_slots_clear", 32'(console_data), 32'h3C);
        check("post_rst_hit", 32'(hit), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cheat_patch_engine.md
# cheat_patch_engine

Parametrised multi-slot cheat substitution engine that sits between the console cartridge bus and the cartridge ROM. It replaces the single-purpose three-code patcher with NUM_SLOTS independently loadable slots, each having an optional compare value. A slot with compare enabled substitutes its byte only when the original ROM byte matches. Slots are loaded through a valid/ready port while in the load phase. Substitution arms on the next reset-vector fetch and stays armed until reset.

## Interface

Parameters:
- NUM_SLOTS, 8: number of cheat slots (1..16).
- ADDR_WIDTH, 13: console/cart address width; bit ADDR_WIDTH-1 is the cartridge-select line.
- DATA_WIDTH, 8: bus data width.
- DEBOUNCE, 2: number of extra consecutive samples for which CONSOLE_ADDR must be stable before it is accepted (1..7).
- RESET_VECTOR, 13'h1FFC: accepted address that completes arming.

SLOT_W = max(1, clog2(NUM_SLOTS)).

Ports:
- CLOCK_50 in 1: sole clock.
- RESET_N in 1: asynchronous active-low reset.
- CONSOLE_ADDR in ADDR_WIDTH: raw console address bus.
- CART_DATA in DATA_WIDTH: cartridge ROM data.
- CART_ADDR out ADDR_WIDTH: registered address to the cartridge ROM.
- CONSOLE_DATA out DATA_WIDTH: data driven to the console.
- CONSOLE_DATA_OE out 1: tri-state enable for CONSOLE_DATA, applied at top level.
- LOAD_VALID in 1: slot write request.
- LOAD_READY out 1: high only in the LOAD state.
- LOAD_SLOT in SLOT_W: slot index.
- LOAD_ADDR in ADDR_WIDTH: match address; 0 means the slot is unused.
- LOAD_DATA in DATA_WIDTH: replacement byte.
- LOAD_COMPARE in DATA_WIDTH: compare byte.
- LOAD_USE_COMPARE in 1: enables compare mode for the slot.
- LOAD_ENABLE in 1: enables the slot.
- ARM in 1: single-cycle request to go live.
- ACTIVE out 1: substitution live.
- HIT out NUM_SLOTS: sticky per-slot flag, set on the first substitution by that slot.

## Operation

States:
- LOAD (entered on reset):
  - The load handshake is open.
  - CART_ADDR tracks the accepted address.
  - CONSOLE_DATA_OE = 0.
- PENDING:
  - Entered on ARM=1 in LOAD.
  - The load port is closed.
  - Moves to ACTIVE on the edge where the accepted address becomes RESET_VECTOR.
- ACTIVE:
  - Passthrough with substitution.
  - Left only by reset.
  - ARM is ignored in PENDING and ACTIVE.

Debounce:
- raw_q registers CONSOLE_ADDR every cycle.
- cnt is cleared when CONSOLE_ADDR != raw_q; otherwise it increments, saturating at DEBOUNCE.
- addr_q loads raw_q on the edge where cnt == DEBOUNCE-1 and CONSOLE_ADDR == raw_q.
- Result: an address must be present on DEBOUNCE+1 consecutive edges to be accepted.

Loading:
- A transfer occurs on a clock edge with LOAD_VALID & LOAD_READY.
- The transfer writes all five fields into slot LOAD_SLOT.
- LOAD_SLOT >= NUM_SLOTS: the handshake completes and the data is discarded.
- ARM and LOAD_VALID in the same cycle: the write is accepted, then the state moves to PENDING.

Matching:
- Slot i matches when all of the following hold:
  - enable_i = 1;
  - addr_i != 0;
  - addr_i == the address currently being served;
  - use_compare_i = 0, or the sampled ROM byte == compare_i.
- If several slots match, the lowest index wins.
- CONSOLE_DATA = the winning slot's LOAD_DATA if ACTIVE and a slot matches; otherwise the sampled ROM byte.
- CONSOLE_DATA_OE = 1 when the state is PENDING or ACTIVE and the served address has bit ADDR_WIDTH-1 set; otherwise 0.
- HIT[i] is set when slot i wins and the state is ACTIVE. It is cleared only by reset.

Reset values:
- CART_ADDR 0.
- CONSOLE_DATA 0.
- CONSOLE_DATA_OE 0.
- LOAD_READY 1.
- ACTIVE 0.
- HIT 0.
- All slots are disabled and zeroed.
- raw_q, cnt and addr_q are 0.
- Reset asserted mid-operation returns everything to these values immediately, independent of the clock.

## Timing

Pipeline, with edge n being the edge that loads addr_q = A:
- n+1: CART_ADDR = A. The address-match vector for A is registered alongside it.
- n+2: data_q = CART_DATA. The ROM must settle in under one 20 ns cycle.
- n+2: the address-match vector is delayed once more to align with data_q.
- n+3: CONSOLE_DATA and CONSOLE_DATA_OE reflect A. The compare check and slot priority are evaluated on data_q here.

Latency and throughput:
- Total latency from the first edge showing a new address to valid CONSOLE_DATA is DEBOUNCE+4 edges.
- That is 120 ns at the defaults, well inside the console bus cycle.
- ACTIVE rises on edge n+1 after RESET_VECTOR is accepted at edge n.
- Substitution begins with the first address accepted after that.
- An address change mid-pipeline does not stall; each accepted address flows through independently.

## Test plan

- **Reset and passthrough.**
  - Stimulus: ROM[$1234] = $A5; hold CONSOLE_ADDR = $1234 for 10 cycles in LOAD.
  - Required: CART_ADDR = $1234 after DEBOUNCE+2 edges; CONSOLE_DATA = $A5; CONSOLE_DATA_OE = 0; ACTIVE = 0.
- **Debounce.**
  - Stimulus: toggle CONSOLE_ADDR between $1000 and $1001 every cycle, then hold $1001 for 2 edges with DEBOUNCE = 2.
  - Required: addr_q is never updated. Holding for a third edge makes it accepted.
- **Arming.**
  - Stimulus: load slot 0 = {$1100, $EA, enable}; pulse ARM; present $1100, then $1FFC, then $1100.
  - Required: the first $1100 returns the ROM byte with OE = 1 and ACTIVE = 0; ACTIVE = 1 after $1FFC; the second $1100 returns $EA and HIT[0] = 1.
- **Compare mode.**
  - Stimulus: slot 3 = {$1200, $00, compare $05, use_compare}; ACTIVE; serve $1200 with ROM = $05, then with ROM = $06.
  - Required: the first returns $00 and sets HIT[3]; the second returns $06.
- **Priority and boundaries.**
  - Stimulus: slots 1 and 2 both address $1300, data $11 and $22; slot 5 address 0, enabled; LOAD_SLOT = NUM_SLOTS; a write attempted in ACTIVE.
  - Required: $1300 returns $11; address 0 is never substituted; the out-of-range and ACTIVE writes leave all slots unchanged.
- **Reset mid-run.**
  - Stimulus: drop RESET_N while ACTIVE with a hit pending in the pipeline.
  - Required: with no clock edge, OE = 0, ACTIVE = 0, HIT = 0, LOAD_READY = 1, and the slots are cleared.
